// File: rtl/pulse_detect_mc.sv
// pulse_detect_mc: multi-channel synchronised, glitch-filtered edge detector
// with per-channel edge mode, one-cycle strobe, sticky flag and event count.
module pulse_detect_mc #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       data_in,
  input  logic [2*CH-1:0]     edge_mode,
  input  logic [CH-1:0]       clr,
  output logic [CH-1:0]       pulse_out,
  output logic [CH-1:0]       level_out,
  output logic [CH-1:0]       sticky,
  output logic [CH*CNT_W-1:0] evt_cnt
);

  localparam logic [3:0]       FLAST = 4'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CH-1:0] sync_out;

  generate
    if (SYNC_STAGES == 0) begin : g_raw
      assign sync_out = data_in;
    end else begin : g_sync
      logic [CH-1:0] q [SYNC_STAGES];

      // Shift raw inputs through the synchroniser chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < SYNC_STAGES; j++) q[j] <= '0;
        end else begin
          q[0] <= data_in;
          for (int j = 1; j < SYNC_STAGES; j++) q[j] <= q[j-1];
        end
      end

      assign sync_out = q[SYNC_STAGES-1];
    end
  endgenerate

  generate
    for (genvar i = 0; i < CH; i++) begin : g_ch
      logic [3:0]       fc;
      logic             lvl;
      logic             pls;
      logic             stk;
      logic [CNT_W-1:0] cnt;
      logic             diff;
      logic             hit;
      logic             pulse_nxt;

      // A toggle from 0 is a rising edge (mode bit 0), from 1 falling (bit 1)
      assign diff      = sync_out[i] ^ lvl;
      assign hit       = diff && (fc == FLAST);
      assign pulse_nxt = hit &&
                         (lvl ? edge_mode[2*i+1] : edge_mode[2*i]);

      // Stability filter: accept a new level after FILT_LEN mismatches
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fc  <= '0;
          lvl <= 1'b0;
          pls <= 1'b0;
        end else begin
          pls <= pulse_nxt;
          if (!diff || hit) fc <= '0;
          else              fc <= fc + 4'd1;
          if (hit) lvl <= ~lvl;
        end
      end

      // Count and flag strobes; a strobe outranks a same-cycle clear
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stk <= 1'b0;
          cnt <= '0;
        end else if (pls) begin
          stk <= 1'b1;
          if (clr[i])            cnt <= ONE;
          else if (cnt != CMAX)  cnt <= cnt + ONE;
        end else if (clr[i]) begin
          stk <= 1'b0;
          cnt <= '0;
        end
      end

      assign pulse_out[i]                 = pls;
      assign level_out[i]                 = lvl;
      assign sticky[i]                    = stk;
      assign evt_cnt[i*CNT_W +: CNT_W]    = cnt;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_detect_mc.sv
// tb_pulse_detect_mc: directed stimulus on a default build and an
// unsynchronised single-cycle-filter build, checked against a window model.
module tb_pulse_detect_mc;

  localparam int CH = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] data_in;
  logic [2*CH-1:0] edge_mode;
  logic [CH-1:0] clr;

  logic [CH-1:0]    pa, la, sa;
  logic [CH-1:0]    pb, lb, sb;
  logic [CH*CW-1:0] ca, cb;

  int vecs = 0;
  int errs = 0;

  pulse_detect_mc #(.CH(CH), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(CW)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .edge_mode(edge_mode),
    .clr(clr), .pulse_out(pa), .level_out(la), .sticky(sa), .evt_cnt(ca));

  pulse_detect_mc #(.CH(CH), .SYNC_STAGES(0), .FILT_LEN(1), .CNT_W(CW)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .edge_mode(edge_mode),
    .clr(clr), .pulse_out(pb), .level_out(lb), .sticky(sb), .evt_cnt(cb));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: input seen by the filter is data_in delayed by S edges; the level
  // flips when the last F filter inputs all disagree with it.
  logic [CH-1:0] samp [2][2];
  logic [CH-1:0] fh   [2][3];
  logic [CH-1:0] m_lvl [2];
  logic [CH-1:0] m_pls [2];
  logic [CH-1:0] m_stk [2];
  int            m_cnt [2][CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        samp[d][0] <= '0; samp[d][1] <= '0;
        fh[d][0] <= '0; fh[d][1] <= '0; fh[d][2] <= '0;
        m_lvl[d] <= '0; m_pls[d] <= '0; m_stk[d] <= '0;
        for (int i = 0; i < CH; i++) m_cnt[d][i] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic [CH-1:0] f;
        int flen;
        f    = (d == 0) ? samp[0][1] : data_in;
        flen = (d == 0) ? 3 : 1;
        samp[d][0] <= data_in;
        samp[d][1] <= samp[d][0];
        fh[d][0] <= f;
        fh[d][1] <= fh[d][0];
        fh[d][2] <= fh[d][1];
        for (int i = 0; i < CH; i++) begin
          logic all_diff;
          if (m_pls[d][i]) begin
            m_stk[d][i] <= 1'b1;
            m_cnt[d][i] <= clr[i] ? 1 :
                           (m_cnt[d][i] == 255 ? 255 : m_cnt[d][i] + 1);
          end else if (clr[i]) begin
            m_stk[d][i] <= 1'b0;
            m_cnt[d][i] <= 0;
          end
          all_diff = (f[i] != m_lvl[d][i]);
          for (int k = 0; k < flen - 1; k++)
            if (fh[d][k][i] == m_lvl[d][i]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[d][i] <= ~m_lvl[d][i];
            m_pls[d][i] <= m_lvl[d][i] ? edge_mode[2*i+1] : edge_mode[2*i];
          end else begin
            m_pls[d][i] <= 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [31:0] pack_cnt(input int d);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*CW +: CW] = m_cnt[d][i][CW-1:0];
    return v;
  endfunction

  // Compare every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("a.pulse",  {28'b0, pa}, {28'b0, m_pls[0]});
      chk("a.level",  {28'b0, la}, {28'b0, m_lvl[0]});
      chk("a.sticky", {28'b0, sa}, {28'b0, m_stk[0]});
      chk("a.cnt",    ca,          pack_cnt(0));
      chk("b.pulse",  {28'b0, pb}, {28'b0, m_pls[1]});
      chk("b.level",  {28'b0, lb}, {28'b0, m_lvl[1]});
      chk("b.sticky", {28'b0, sb}, {28'b0, m_stk[1]});
      chk("b.cnt",    cb,          pack_cnt(1));
    end
  end

  initial begin
    rst = 1'b0; data_in = '0; edge_mode = '0; clr = '0;
    #1 rst = 1'b1;
    step(2);
    chk("rst.pulse", {28'b0, pa}, 32'h0);
    chk("rst.level", {28'b0, la}, 32'h0);
    chk("rst.sticky", {28'b0, sa}, 32'h0);
    chk("rst.cnt", ca, 32'h0);
    rst = 1'b0;
    edge_mode = 8'b01_11_11_01;
    step(5);

    // Single rising edge on ch0: strobe four edges after sampling
    data_in[0] = 1'b1;
    step(4);
    chk("t1.level_early", {31'b0, la[0]}, 32'd0);
    chk("t1.pulse_early", {31'b0, pa[0]}, 32'd0);
    step(1);
    chk("t1.pulse", {31'b0, pa[0]}, 32'd1);
    chk("t1.level", {31'b0, la[0]}, 32'd1);
    step(1);
    chk("t1.pulse_once", {31'b0, pa[0]}, 32'd0);
    chk("t1.cnt0", {24'b0, ca[7:0]}, 32'd1);
    chk("t1.sticky0", {31'b0, sa[0]}, 32'd1);
    chk("t1.sticky_other", {29'b0, sa[3:1]}, 32'd0);
    step(15);

    // Glitches on ch1: 2-cycle rejected, 3-cycle accepted
    data_in[1] = 1'b1;
    step(1);
    chk("t6.b_pulse1", {31'b0, pb[1]}, 32'd1);
    step(1);
    data_in[1] = 1'b0;
    step(8);
    chk("t2.level1", {31'b0, la[1]}, 32'd0);
    chk("t2.cnt1", {24'b0, ca[15:8]}, 32'd0);
    data_in[1] = 1'b1;
    step(3);
    data_in[1] = 1'b0;
    step(10);
    chk("t2.cnt1_both", {24'b0, ca[15:8]}, 32'd2);

    // Square wave on ch2 in both mode, then falling only
    for (int p = 0; p < 3; p++) begin
      data_in[2] = 1'b1; step(8);
      data_in[2] = 1'b0; step(8);
    end
    chk("t3.cnt2", {24'b0, ca[23:16]}, 32'd6);
    edge_mode[5:4] = 2'b10;
    for (int p = 0; p < 2; p++) begin
      data_in[2] = 1'b1; step(8);
      data_in[2] = 1'b0; step(8);
    end
    chk("t3.cnt2_fall", {24'b0, ca[23:16]}, 32'd8);

    // Saturation on ch3, then clear
    for (int p = 0; p < 260; p++) begin
      data_in[3] = 1'b1; step(4);
      data_in[3] = 1'b0; step(4);
    end
    chk("t4.cnt3_sat", {24'b0, ca[31:24]}, 32'd255);
    chk("t4.sticky3", {31'b0, sa[3]}, 32'd1);
    clr[3] = 1'b1;
    step(1);
    clr[3] = 1'b0;
    chk("t4.cnt3_clr", {24'b0, ca[31:24]}, 32'd0);
    chk("t4.sticky3_clr", {31'b0, sa[3]}, 32'd0);

    // Clear colliding with a strobe on ch0 after five counted events
    clr[0] = 1'b1; step(1); clr[0] = 1'b0;
    for (int p = 0; p < 5; p++) begin
      data_in[0] = 1'b0; step(4);
      data_in[0] = 1'b1; step(4);
    end
    step(2);
    chk("t5.cnt0_pre", {24'b0, ca[7:0]}, 32'd5);
    data_in[0] = 1'b0; step(4);
    data_in[0] = 1'b1; step(5);
    chk("t5.pulse0", {31'b0, pa[0]}, 32'd1);
    clr[0] = 1'b1;
    step(1);
    clr[0] = 1'b0;
    chk("t5.cnt0", {24'b0, ca[7:0]}, 32'd1);
    chk("t5.sticky0", {31'b0, sa[0]}, 32'd1);

    // Async reset in the middle of a ch3 transition
    data_in[3] = 1'b1;
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("t6.a_out", {pa, la, sa, 20'b0}, 32'h0);
    chk("t6.a_cnt", ca, 32'h0);
    chk("t6.b_out", {pb, lb, sb, 20'b0}, 32'h0);
    chk("t6.b_cnt", cb, 32'h0);
    data_in[3] = 1'b0;
    step(2);
    rst = 1'b0;
    step(10);
    chk("t6.level3", {31'b0, la[3]}, 32'd0);
    chk("t6.cnt3", {24'b0, ca[31:24]}, 32'd0);
    chk("t6.level0", {31'b0, la[0]}, 32'd1);
    chk("t6.cnt0", {24'b0, ca[7:0]}, 32'd1);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
